// File: rtl/sdram_arbit_if.sv
// Bundle between the SDRAM sub-controllers (init, aref, write, read), the
// command arbiter and the SDRAM command/address pins.
// slave modport: the arbiter's view. master modport: the sub-controller/pin side.
interface sdram_arbit_if;
  // init block
  logic [3:0]  init_cmd;
  logic [12:0] init_addr;
  logic        flag_init_end;
  // auto-refresh block
  logic        ref_req;
  logic        ref_en;
  logic        flag_ref_end;
  logic [3:0]  aref_cmd;
  logic [12:0] aref_addr;
  // write block
  logic        wr_req;
  logic        wr_en;
  logic        flag_wr_end;
  logic [3:0]  wr_cmd;
  logic [12:0] wr_addr;
  logic [1:0]  wr_ba;
  // read block
  logic        rd_req;
  logic        rd_en;
  logic        flag_rd_end;
  logic [3:0]  rd_cmd;
  logic [12:0] rd_addr;
  logic [1:0]  rd_ba;
  // SDRAM pins and status
  logic        sdram_cs_n;
  logic        sdram_ras_n;
  logic        sdram_cas_n;
  logic        sdram_we_n;
  logic [12:0] sdram_addr;
  logic [1:0]  sdram_ba;
  logic [2:0]  arb_state;
  logic        err_timeout;

  modport slave (
    input  init_cmd, init_addr, flag_init_end,
    input  ref_req, flag_ref_end, aref_cmd, aref_addr,
    input  wr_req, flag_wr_end, wr_cmd, wr_addr, wr_ba,
    input  rd_req, flag_rd_end, rd_cmd, rd_addr, rd_ba,
    output ref_en, wr_en, rd_en,
    output sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    output sdram_addr, sdram_ba, arb_state, err_timeout
  );

  modport master (
    output init_cmd, init_addr, flag_init_end,
    output ref_req, flag_ref_end, aref_cmd, aref_addr,
    output wr_req, flag_wr_end, wr_cmd, wr_addr, wr_ba,
    output rd_req, flag_rd_end, rd_cmd, rd_addr, rd_ba,
    input  ref_en, wr_en, rd_en,
    input  sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    input  sdram_addr, sdram_ba, arb_state, err_timeout
  );
endinterface

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: grants one of init/aref/write/read at a time and muxes
// the owner's cmd/addr/ba onto the pins. Grant pulse 1 cycle after the request is
// seen in ARBIT; mux adds no latency. Requests arriving mid-grant wait (no preemption).
// Ports: sclk, s_rst_n (async, active-low), bus (sdram_arbit_if.slave).
// Optional: define ARB_TIMEOUT_EN to force-release a grant after TIMEOUT_CYC
// cycles and pulse err_timeout; otherwise grants are held until the end flag.
module sdram_arbit #(
  parameter int         TIMEOUT_CYC = 1023,
  parameter logic [3:0] CMD_NOP     = 4'b0111
) (
  input logic          sclk,
  input logic          s_rst_n,
  sdram_arbit_if.slave bus
);

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    ARBIT = 3'd1,
    AREF  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } state_t;

  // The hold counter is 10 bits wide, so the timeout must fit in it.
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 1023) begin : g_bad_timeout
    $error("sdram_arbit: TIMEOUT_CYC must be in 1..1023");
  end

  state_t      state;
  logic        last_wr;
  logic        ref_en_q;
  logic        wr_en_q;
  logic        rd_en_q;
  logic        grant_end;
  logic [3:0]  cmd_sel;
  logic [12:0] addr_sel;
  logic [1:0]  ba_sel;

  // End flag of the current owner only; flags from other blocks are ignored.
  assign grant_end = ((state == AREF)  && bus.flag_ref_end) ||
                     ((state == WRITE) && bus.flag_wr_end)  ||
                     ((state == READ)  && bus.flag_rd_end);

`ifdef ARB_TIMEOUT_EN
  localparam logic [9:0] HOLD_LAST = 10'(TIMEOUT_CYC - 1);
  logic [9:0] hold_cnt;
  logic       err_q;
`endif

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state    <= INIT;
      last_wr  <= 1'b0;
      ref_en_q <= 1'b0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      // Grant enables and the timeout flag are single-cycle pulses.
      ref_en_q <= 1'b0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
      case (state)
        INIT: begin
          if (bus.flag_init_end) state <= ARBIT;
        end
        ARBIT: begin
`ifdef ARB_TIMEOUT_EN
          hold_cnt <= '0;
`endif
          if (bus.ref_req) begin
            state    <= AREF;
            ref_en_q <= 1'b1;
          end else if (bus.wr_req && (!bus.rd_req || !last_wr)) begin
            // Write wins when alone, or on a tie when the last grant was a read.
            state   <= WRITE;
            wr_en_q <= 1'b1;
            last_wr <= 1'b1;
          end else if (bus.rd_req) begin
            state   <= READ;
            rd_en_q <= 1'b1;
            last_wr <= 1'b0;
          end
        end
        AREF, WRITE, READ: begin
          if (grant_end) begin
            state <= ARBIT;
          end
`ifdef ARB_TIMEOUT_EN
          else if (hold_cnt == HOLD_LAST) begin
            state <= ARBIT;
            err_q <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 10'd1;
          end
`endif
        end
        default: state <= INIT;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  assign bus.err_timeout = err_q;
`else
  assign bus.err_timeout = 1'b0;
`endif

  assign bus.ref_en    = ref_en_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.arb_state = state;

  // Sub-block commands are already registered, so select straight off state.
  always_comb begin
    cmd_sel  = CMD_NOP;
    addr_sel = '0;
    ba_sel   = '0;
    case (state)
      INIT: begin
        cmd_sel  = bus.init_cmd;
        addr_sel = bus.init_addr;
      end
      AREF: begin
        cmd_sel  = bus.aref_cmd;
        addr_sel = bus.aref_addr;
      end
      WRITE: begin
        cmd_sel  = bus.wr_cmd;
        addr_sel = bus.wr_addr;
        ba_sel   = bus.wr_ba;
      end
      READ: begin
        cmd_sel  = bus.rd_cmd;
        addr_sel = bus.rd_addr;
        ba_sel   = bus.rd_ba;
      end
      default: begin
        cmd_sel  = CMD_NOP;
        addr_sel = '0;
        ba_sel   = '0;
      end
    endcase
  end

  assign {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n} = cmd_sel;
  assign bus.sdram_addr = addr_sel;
  assign bus.sdram_ba   = ba_sel;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit: reset/init sequence, a table of per-cycle
// request/end-flag vectors with expected state, grant pulses and pin values,
// then hand-written sequences for hold timeout and reset during a grant.
module tb_sdram_arbit;

  logic sclk = 1'b0;
  logic s_rst_n = 1'b0;

  sdram_arbit_if bus ();

  sdram_arbit #(
    .TIMEOUT_CYC (8),
    .CMD_NOP     (4'b0111)
  ) dut (
    .sclk    (sclk),
    .s_rst_n (s_rst_n),
    .bus     (bus)
  );

  always #5 sclk = ~sclk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] req;  // {ref_req, wr_req, rd_req}
    logic [2:0] fin;  // {flag_ref_end, flag_wr_end, flag_rd_end}
    logic [2:0] st;   // expected arb_state after the edge
    logic [2:0] en;   // expected {ref_en, wr_en, rd_en}
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [2:0] req, input logic [2:0] fin,
                              input logic [2:0] st, input logic [2:0] en);
    vec_t v;
    v.req = req;
    v.fin = fin;
    v.st  = st;
    v.en  = en;
    return v;
  endfunction

  // Expected {cmd, addr, ba} on the pins for each state, from the bench's own stimulus.
  function automatic logic [18:0] exp_bus(input logic [2:0] st);
    case (st)
      3'd0:    return {4'b0010, 13'h0400, 2'd0};
      3'd1:    return {4'b0111, 13'h0000, 2'd0};
      3'd2:    return {4'b0001, 13'h0011, 2'd0};
      3'd3:    return {4'b0100, 13'h0123, 2'd2};
      3'd4:    return {4'b0101, 13'h0456, 2'd1};
      default: return 19'h0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] st, input logic [2:0] en,
                         input logic err);
    chk({tag, ".state"}, 32'(bus.arb_state), 32'(st));
    chk({tag, ".en"}, 32'({bus.ref_en, bus.wr_en, bus.rd_en}), 32'(en));
    chk({tag, ".pins"}, 32'({bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n,
                             bus.sdram_we_n, bus.sdram_addr, bus.sdram_ba}),
        32'(exp_bus(st)));
    chk({tag, ".err"}, 32'(bus.err_timeout), 32'(err));
  endtask

  task automatic tick;
    @(posedge sclk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.init_cmd      = 4'b0010;
    bus.init_addr     = 13'h0400;
    bus.aref_cmd      = 4'b0001;
    bus.aref_addr     = 13'h0011;
    bus.wr_cmd        = 4'b0100;
    bus.wr_addr       = 13'h0123;
    bus.wr_ba         = 2'd2;
    bus.rd_cmd        = 4'b0101;
    bus.rd_addr       = 13'h0456;
    bus.rd_ba         = 2'd1;
    bus.flag_init_end = 1'b0;
    {bus.ref_req, bus.wr_req, bus.rd_req}                = 3'b000;
    {bus.flag_ref_end, bus.flag_wr_end, bus.flag_rd_end} = 3'b000;

    // ARBIT=1 AREF=2 WRITE=3 READ=4; each row: inputs for one cycle -> outputs next cycle
    tbl.push_back(mk(3'b000, 3'b000, 3'd1, 3'b000)); // idle stays in ARBIT
    tbl.push_back(mk(3'b100, 3'b000, 3'd2, 3'b100)); // refresh grant
    tbl.push_back(mk(3'b000, 3'b000, 3'd2, 3'b000)); // aref clears ref_req
    tbl.push_back(mk(3'b000, 3'b000, 3'd2, 3'b000));
    tbl.push_back(mk(3'b000, 3'b000, 3'd2, 3'b000));
    tbl.push_back(mk(3'b000, 3'b100, 3'd1, 3'b000)); // ref end -> ARBIT
    tbl.push_back(mk(3'b000, 3'b010, 3'd1, 3'b000)); // stray wr end ignored
    tbl.push_back(mk(3'b111, 3'b000, 3'd2, 3'b100)); // all three: refresh first
    tbl.push_back(mk(3'b011, 3'b000, 3'd2, 3'b000));
    tbl.push_back(mk(3'b011, 3'b100, 3'd1, 3'b000));
    tbl.push_back(mk(3'b011, 3'b000, 3'd3, 3'b010)); // last_wr=0 -> write
    tbl.push_back(mk(3'b001, 3'b000, 3'd3, 3'b000));
    tbl.push_back(mk(3'b001, 3'b001, 3'd3, 3'b000)); // rd end ignored in WRITE
    tbl.push_back(mk(3'b001, 3'b010, 3'd1, 3'b000));
    tbl.push_back(mk(3'b001, 3'b000, 3'd4, 3'b001)); // then read
    tbl.push_back(mk(3'b000, 3'b000, 3'd4, 3'b000));
    tbl.push_back(mk(3'b000, 3'b001, 3'd1, 3'b000));
    tbl.push_back(mk(3'b011, 3'b000, 3'd3, 3'b010)); // both held: W
    tbl.push_back(mk(3'b011, 3'b000, 3'd3, 3'b000)); // no re-pulse while held
    tbl.push_back(mk(3'b011, 3'b010, 3'd1, 3'b000));
    tbl.push_back(mk(3'b011, 3'b000, 3'd4, 3'b001)); // R
    tbl.push_back(mk(3'b011, 3'b001, 3'd1, 3'b000));
    tbl.push_back(mk(3'b011, 3'b000, 3'd3, 3'b010)); // W
    tbl.push_back(mk(3'b111, 3'b000, 3'd3, 3'b000)); // refresh during write waits
    tbl.push_back(mk(3'b111, 3'b000, 3'd3, 3'b000));
    tbl.push_back(mk(3'b101, 3'b010, 3'd1, 3'b000));
    tbl.push_back(mk(3'b101, 3'b000, 3'd2, 3'b100)); // refresh ahead of read
    tbl.push_back(mk(3'b001, 3'b000, 3'd2, 3'b000));
    tbl.push_back(mk(3'b001, 3'b100, 3'd1, 3'b000));
    tbl.push_back(mk(3'b001, 3'b000, 3'd4, 3'b001));
    tbl.push_back(mk(3'b000, 3'b001, 3'd1, 3'b000));

    // Reset state
    repeat (3) tick();
    chk_out("reset", 3'd0, 3'b000, 1'b0);

    // Init: flag_init_end rises on cycle 10 after reset release
    s_rst_n = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk_out("init_wait", 3'd0, 3'b000, 1'b0);
    end
    bus.flag_init_end = 1'b1;
    #1;
    chk_out("init_flag_cycle", 3'd0, 3'b000, 1'b0);
    tick();
    chk_out("init_done", 3'd1, 3'b000, 1'b0);
    bus.flag_init_end = 1'b0; // dropping it later must not matter

    foreach (tbl[i]) begin
      {bus.ref_req, bus.wr_req, bus.rd_req}                = tbl[i].req;
      {bus.flag_ref_end, bus.flag_wr_end, bus.flag_rd_end} = tbl[i].fin;
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].st, tbl[i].en, 1'b0);
    end
    {bus.ref_req, bus.wr_req, bus.rd_req}                = 3'b000;
    {bus.flag_ref_end, bus.flag_wr_end, bus.flag_rd_end} = 3'b000;

    // Write grant with no end flag
    bus.wr_req = 1'b1;
    tick();
    chk_out("hold_grant", 3'd3, 3'b010, 1'b0);
    bus.wr_req = 1'b0;
`ifdef ARB_TIMEOUT_EN
    for (int c = 2; c <= 8; c++) begin
      tick();
      chk_out($sformatf("hold_c%0d", c), 3'd3, 3'b000, 1'b0);
    end
    tick();
    chk_out("timeout_release", 3'd1, 3'b000, 1'b1);
    tick();
    chk_out("timeout_after", 3'd1, 3'b000, 1'b0);
`else
    for (int c = 2; c <= 20; c++) begin
      tick();
      chk_out($sformatf("hold_c%0d", c), 3'd3, 3'b000, 1'b0);
    end
`endif

    // Back to ARBIT either way (flag is ignored if already there)
    bus.flag_wr_end = 1'b1;
    tick();
    bus.flag_wr_end = 1'b0;
    chk_out("release", 3'd1, 3'b000, 1'b0);

    // Reset asserted mid-grant, while the enable pulse is high
    bus.wr_req = 1'b1;
    tick();
    chk_out("pre_reset_grant", 3'd3, 3'b010, 1'b0);
    bus.wr_req = 1'b0;
    #2;
    s_rst_n = 1'b0;
    #1;
    chk_out("mid_grant_reset", 3'd0, 3'b000, 1'b0);
    bus.flag_init_end = 1'b1;
    tick();
    chk_out("reset_held", 3'd0, 3'b000, 1'b0);
    s_rst_n = 1'b1;
    tick();
    chk_out("reinit_done", 3'd1, 3'b000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_arbit.md
Name: sdram_arbit

Overview:
Command arbiter between the SDRAM sub-controllers (init, auto-refresh, write, read) and the SDRAM pins. It collects the request lines, grants exactly one sub-block at a time with a one-cycle enable pulse, and holds that grant until the sub-block's end flag. While a sub-block holds the grant, its 4-bit command, address and bank are routed to the SDRAM command bus. It is the grant side of the refresh handshake: it consumes ref_req and returns ref_en.

Parameters:
TIMEOUT_CYC, 1023, maximum cycles a grant may be held before a forced release (used only with ARB_TIMEOUT_EN).
CMD_NOP, 4'b0111, command driven when no sub-block owns the bus; encoding is {cs_n, ras_n, cas_n, we_n}.

Ports:
sclk  input  1  system clock
s_rst_n  input  1  reset
init_cmd  input  4  init block command
init_addr  input  13  init block address
flag_init_end  input  1  init complete, level, stays high
ref_req  input  1  refresh request, level; aref block clears it one cycle after ref_en
ref_en  output  1  refresh grant pulse
flag_ref_end  input  1  refresh sequence done
aref_cmd  input  4  refresh command
aref_addr  input  13  refresh address
wr_req  input  1  write request, level
wr_en  output  1  write grant pulse
flag_wr_end  input  1  write burst done
wr_cmd  input  4  write command
wr_addr  input  13  write address
wr_ba  input  2  write bank
rd_req  input  1  read request, level
rd_en  output  1  read grant pulse
flag_rd_end  input  1  read burst done
rd_cmd  input  4  read command
rd_addr  input  13  read address
rd_ba  input  2  read bank
sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  output  1 each  SDRAM command pins
sdram_addr  output  13  SDRAM address
sdram_ba  output  2  SDRAM bank
arb_state  output  3  current state, for debug
err_timeout  output  1  forced-release pulse

Behaviour:
- Reset is s_rst_n, asynchronous, active-low; clock is sclk. All state is in the sclk domain.
- Reset values: state INIT; ref_en, wr_en and rd_en are 0; last_wr is 0; err_timeout is 0.
- States and encodings: INIT=0, ARBIT=1, AREF=2, WRITE=3, READ=4.
- INIT goes to ARBIT on the first cycle flag_init_end=1.
- ARBIT priority on the same cycle: ref_req > (wr_req / rd_req).
  - Refresh: ref_req=1 moves the state to AREF.
  - Both write and read pending: round-robin. Go to READ if last_wr=1, otherwise WRITE.
  - Only one of write or read pending: go to the requested state.
  - No request: stay in ARBIT.
- Grant pulse: ref_en, wr_en or rd_en is registered. It is high for exactly one cycle, the first cycle in the new state, and is never reasserted while in that state, even if the request is still high.
- last_wr is updated when WRITE or READ is entered: 1 on WRITE, 0 on READ.
- AREF goes to ARBIT the cycle after flag_ref_end=1. WRITE and READ behave the same with flag_wr_end and flag_rd_end.
- End flags received outside the matching state are ignored.
- Minimum gap between two grants is 1 cycle spent in ARBIT.
- Bus mux, combinational on the registered state with zero added latency. The sub-block commands are already registered.
  - INIT: init_cmd / init_addr, ba=0.
  - AREF: aref_cmd / aref_addr, ba=0.
  - WRITE: wr_cmd / wr_addr / wr_ba.
  - READ: rd_cmd / rd_addr / rd_ba.
  - ARBIT: CMD_NOP, addr=0, ba=0.
- Command pins: {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = selected command.
- If a request arrives mid-grant, it waits; no preemption. A refresh that arrives during WRITE is served at the next ARBIT.
- If flag_init_end drops after leaving INIT, it is ignored.
- Reset asserted mid-grant returns to INIT immediately, with all enables 0 and the bus at init_cmd.

Optional Feature:
ARB_TIMEOUT_EN:
- Defined: a 10-bit hold counter clears on entry to AREF, WRITE or READ and increments each cycle in that state. When it reaches TIMEOUT_CYC without the end flag, the next state is ARBIT and err_timeout pulses for 1 cycle.
- Undefined: no counter is built, err_timeout is tied to 0, and a grant is held until its end flag.

Test Plan:
- Reset, then flag_init_end rises at cycle 10 -> arb_state=0 through cycle 10, =1 at cycle 11; the pins follow init_cmd until then and read 0111 in ARBIT.
- ref_req=1 in ARBIT; aref drives aref_cmd=0001 for one cycle; flag_ref_end at cycle +4 -> ref_en high exactly 1 cycle; the pins read 0001 that cycle; state is ARBIT on cycle +5.
- ref_req, wr_req and rd_req all rise together -> AREF first, then WRITE, then READ, each with a single enable pulse and ARBIT for 1 cycle between grants.
- wr_req and rd_req held high continuously -> grants alternate W, R, W, R; no two consecutive grants to the same block.
- ref_req rises during WRITE -> no ref_en until flag_wr_end, then the AREF grant follows, ahead of a pending rd_req.
- With ARB_TIMEOUT_EN and TIMEOUT_CYC=8, grant a write and never send flag_wr_end -> ARBIT after 8 cycles, err_timeout pulses once. Without the macro -> stays in WRITE and err_timeout stays 0.
